// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: MMU access widths,
// owner identifiers and the arbiter FSM state encoding.
package mem_arbiter_pkg;

  localparam logic [1:0] MMU_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MMU_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MMU_WIDTH_WORD = 2'd3;

  localparam logic ARB_OWNER_IFU = 1'b0;
  localparam logic ARB_OWNER_LSU = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-client round-robin grant; bit 0 is the IFU, bit 1 the LSU.
// On a tie the client that was not granted last wins.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == ARB_OWNER_IFU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single MMU port between instruction fetch and load/store: one
// access at a time, round-robin on ties, one-cycle command, one-cycle response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic [31:0] ifu_rdata,
  output logic        ifu_valid,
  output logic        ifu_err,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic        lsu_signed,
  input  logic [1:0]  lsu_width,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_valid,
  output logic        lsu_err,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        mem_signed_read,
  output logic [1:0]  mem_data_width,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ready
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

  arb_state_t       state;
  logic             last_grant;
  logic             owner;
  logic             owner_store;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       grant;

  rr_arb2 u_rr_arb2 (
    .req        ({lsu_req, ifu_req}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ARB_IDLE;
      last_grant       <= ARB_OWNER_IFU;
      owner            <= ARB_OWNER_IFU;
      owner_store      <= 1'b0;
      wait_cnt         <= '0;
      ifu_rdata        <= '0;
      ifu_valid        <= 1'b0;
      ifu_err          <= 1'b0;
      lsu_rdata        <= '0;
      lsu_valid        <= 1'b0;
      lsu_err          <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_signed_read  <= 1'b0;
      mem_data_width   <= '0;
      mem_address      <= '0;
      mem_data_in      <= '0;
    end else begin
      ifu_valid <= 1'b0;
      ifu_err   <= 1'b0;
      lsu_valid <= 1'b0;
      lsu_err   <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant != 2'b00) begin
            owner       <= grant[1];
            last_grant  <= grant[1];
            owner_store <= grant[1] & lsu_we;
            state       <= ARB_ISSUE;
            if (grant[1]) begin
              mem_read_enable  <= ~lsu_we;
              mem_write_enable <= lsu_we;
              mem_signed_read  <= lsu_signed;
              mem_data_width   <= lsu_width;
              mem_address      <= lsu_addr;
              mem_data_in      <= lsu_wdata;
            end else begin
              mem_read_enable  <= 1'b1;
              mem_write_enable <= 1'b0;
              mem_signed_read  <= 1'b0;
              mem_data_width   <= MMU_WIDTH_WORD;
              mem_address      <= ifu_addr;
              mem_data_in      <= '0;
            end
          end
        end
        // Enables are a single-cycle pulse; the fields stay put until the next grant.
        ARB_ISSUE: begin
          mem_read_enable  <= 1'b0;
          mem_write_enable <= 1'b0;
          wait_cnt         <= '0;
          state            <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (mem_ready) begin
            state <= ARB_RESP;
            if (owner == ARB_OWNER_IFU) begin
              ifu_rdata <= mem_data_out;
              ifu_valid <= 1'b1;
            end else begin
              if (!owner_store) lsu_rdata <= mem_data_out;
              lsu_valid <= 1'b1;
            end
          end else if (wait_cnt == CNT_MAX) begin
            state <= ARB_RESP;
            if (owner == ARB_OWNER_IFU) begin
              ifu_rdata <= '0;
              ifu_err   <= 1'b1;
              ifu_valid <= 1'b1;
            end else begin
              lsu_rdata <= '0;
              lsu_err   <= 1'b1;
              lsu_valid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected MMU commands and
// responses, monitors compare whenever the DUT issues a command or a valid.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int WAIT_LIMIT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req, lsu_req, lsu_we, lsu_signed;
  logic [1:0]  lsu_width;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic        ifu_valid, ifu_err, lsu_valid, lsu_err;
  logic        mem_read_enable, mem_write_enable, mem_signed_read;
  logic [1:0]  mem_data_width;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_ready = 1'b1;

  mem_arbiter #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata),
    .ifu_valid(ifu_valid), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_signed(lsu_signed),
    .lsu_width(lsu_width), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_valid(lsu_valid), .lsu_err(lsu_err),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_signed_read(mem_signed_read), .mem_data_width(mem_data_width),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, sg;
    logic [1:0]  w;
    logic [31:0] addr, data;
    int          cyc;
  } cmd_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t ifu_q[$];
  rsp_t lsu_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c;

  logic        stuck = 1'b0;
  logic        fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;
  int          ready_delay = 0;
  logic        armed = 1'b0;
  int          busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // MMU stub: data follows the address unless a fixed word is forced.
  assign mem_data_out = fixed_en ? fixed_data : {mem_address[15:0], ~mem_address[15:0]};

  always @(negedge clk) begin
    if (reset) begin
      armed <= 1'b0; busy <= 0; mem_ready <= 1'b1;
    end else if (mem_read_enable || mem_write_enable) begin
      armed <= 1'b1; busy <= ready_delay;
    end else if (armed) begin
      if (busy == 0 && !stuck) begin
        mem_ready <= 1'b1; armed <= 1'b0;
      end else begin
        mem_ready <= 1'b0;
        if (busy > 0) busy <= busy - 1;
      end
    end else begin
      mem_ready <= !stuck;
    end
  end

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic        in_flight = 1'b0;
  logic [1:0]  h_w;
  logic        h_sg;
  logic [31:0] h_addr, h_data;
  logic [31:0] last_ifu = '0, last_lsu = '0;

  // Command monitor, hold monitor and response scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      in_flight = 1'b0; last_ifu = '0; last_lsu = '0;
    end else begin
      if (mem_read_enable || mem_write_enable) begin
        int idx;
        idx = -1;
        foreach (cmd_q[i]) if (cmd_q[i].cyc == cyc) idx = i;
        if (idx < 0) begin
          checks++; failures++;
          $display("FAIL cmd_issue_cycle: command at cycle %0d, none expected", cyc);
        end else begin
          check_vec("cmd_fields",
            {mem_read_enable, mem_write_enable, mem_signed_read, mem_data_width, mem_address, mem_data_in},
            {cmd_q[idx].rd, cmd_q[idx].wr, cmd_q[idx].sg, cmd_q[idx].w, cmd_q[idx].addr, cmd_q[idx].data});
          cmd_q.delete(idx);
        end
        in_flight = 1'b1;
        h_w = mem_data_width; h_sg = mem_signed_read; h_addr = mem_address; h_data = mem_data_in;
      end else if (in_flight && !ifu_valid && !lsu_valid) begin
        check_vec("cmd_hold",
          {mem_read_enable, mem_write_enable, mem_data_width, mem_signed_read, mem_address, mem_data_in},
          {2'b00, h_w, h_sg, h_addr, h_data});
      end
      if (ifu_valid && lsu_valid) check_vec("one_valid", 2'b11, 2'b01);
      if (ifu_valid) begin
        in_flight = 1'b0;
        if (ifu_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ifu_unexpected_valid: valid at cycle %0d, none expected", cyc);
        end else begin
          rsp_t e;
          e = ifu_q.pop_front();
          check_vec("ifu_rdata", ifu_rdata, e.rdata);
          check_vec("ifu_err", ifu_err, e.err);
          check_vec("ifu_valid_cycle", cyc, e.cyc);
          check_vec("lsu_rdata_untouched", lsu_rdata, last_lsu);
          last_ifu = e.rdata;
        end
      end
      if (lsu_valid) begin
        in_flight = 1'b0;
        if (lsu_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL lsu_unexpected_valid: valid at cycle %0d, none expected", cyc);
        end else begin
          rsp_t e;
          e = lsu_q.pop_front();
          check_vec("lsu_rdata", lsu_rdata, e.rdata);
          check_vec("lsu_err", lsu_err, e.err);
          check_vec("lsu_valid_cycle", cyc, e.cyc);
          check_vec("ifu_rdata_untouched", ifu_rdata, last_ifu);
          last_lsu = e.rdata;
        end
      end
    end
  end

  task automatic ifu_access(input logic [31:0] addr, input int issue_c, input int valid_c,
                            input logic [31:0] exp_rd, input logic exp_err);
    bit got;
    cmd_q.push_back('{rd: 1'b1, wr: 1'b0, sg: 1'b0, w: 2'd3, addr: addr, data: 32'h0, cyc: issue_c});
    ifu_q.push_back('{rdata: exp_rd, err: exp_err, cyc: valid_c});
    ifu_addr = addr;
    ifu_req  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ifu_valid) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL ifu_wait_timeout: no ifu_valid by cycle %0d, expected at %0d", cyc, valid_c);
    end
    ifu_req = 1'b0;
  endtask

  task automatic lsu_access(input logic we, input logic sg, input logic [1:0] w,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int issue_c, input int valid_c,
                            input logic [31:0] exp_rd, input logic exp_err, input bit keep);
    bit got;
    cmd_q.push_back('{rd: ~we, wr: we, sg: sg, w: w, addr: addr, data: wdata, cyc: issue_c});
    lsu_q.push_back('{rdata: exp_rd, err: exp_err, cyc: valid_c});
    lsu_we = we; lsu_signed = sg; lsu_width = w; lsu_addr = addr; lsu_wdata = wdata;
    lsu_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (lsu_valid) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL lsu_wait_timeout: no lsu_valid by cycle %0d, expected at %0d", cyc, valid_c);
    end
    if (!keep) lsu_req = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check_vec(name,
      {ifu_rdata, lsu_rdata, mem_address, mem_data_in, mem_data_width, mem_read_enable,
       mem_write_enable, mem_signed_read, ifu_valid, ifu_err, lsu_valid, lsu_err}, '0);
  endtask

  initial begin
    reset = 1'b1; ifu_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_signed = 1'b0;
    lsu_width = 2'd0; ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);

    // Lone fetch, MMU ready immediately.
    fixed_en = 1'b1; fixed_data = 32'h00112233;
    @(negedge clk); c = cyc;
    ifu_access(32'h0000_0004, c + 1, c + 3, 32'h00112233, 1'b0);

    // Tie after reset: LSU, then IFU, then LSU again (LSU held its request).
    fixed_en = 1'b0;
    @(negedge clk); c = cyc;
    fork
      ifu_access(32'h0000_0100, c + 5, c + 7, 32'h0100FEFF, 1'b0);
      begin
        lsu_access(1'b0, 1'b0, 2'd3, 32'h0000_0200, 32'h0, c + 1, c + 3, 32'h0200FDFF, 1'b0, 1'b1);
        lsu_access(1'b0, 1'b0, 2'd3, 32'h0000_0204, 32'h0, c + 9, c + 11, 32'h0204FDFB, 1'b0, 1'b0);
      end
    join

    // Byte store with one busy WAIT cycle; rdata keeps the last load.
    ready_delay = 1;
    @(negedge clk); c = cyc;
    lsu_access(1'b1, 1'b0, 2'd0, 32'h0100_0001, 32'h0000_00AB, c + 1, c + 4, 32'h0204FDFB, 1'b0, 1'b0);
    ready_delay = 0;

    // Signed half load: data passes through unchanged.
    fixed_en = 1'b1; fixed_data = 32'hFFFF8001;
    @(negedge clk); c = cyc;
    lsu_access(1'b0, 1'b1, 2'd1, 32'h0000_0042, 32'h0, c + 1, c + 3, 32'hFFFF8001, 1'b0, 1'b0);

    // Timeout, then a fetch raised in the RESP cycle is issued right after IDLE.
    fixed_en = 1'b0; stuck = 1'b1;
    @(negedge clk); c = cyc;
    lsu_access(1'b0, 1'b0, 2'd3, 32'h0000_0300, 32'h0, c + 1, c + 19, 32'h0, 1'b1, 1'b0);
    stuck = 1'b0;
    ifu_access(32'h0000_0400, c + 21, c + 23, 32'h0400FBFF, 1'b0);

    // Reset in the middle of WAIT drops the access.
    stuck = 1'b1;
    @(negedge clk); c = cyc;
    cmd_q.push_back('{rd: 1'b1, wr: 1'b0, sg: 1'b0, w: 2'd3, addr: 32'h0000_0500, data: 32'h0, cyc: c + 1});
    lsu_we = 1'b0; lsu_signed = 1'b0; lsu_width = 2'd3; lsu_addr = 32'h0000_0500; lsu_wdata = '0;
    lsu_req = 1'b1;
    repeat (3) @(negedge clk);
    check_vec("addr_before_reset", mem_address, 32'h0000_0500);
    #2 reset = 1'b1; lsu_req = 1'b0;
    #1 check_all_zero("reset_async");
    @(negedge clk);
    stuck = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); c = cyc;
    fork
      ifu_access(32'h0000_0600, c + 5, c + 7, 32'h0600F9FF, 1'b0);
      lsu_access(1'b0, 1'b0, 2'd3, 32'h0000_0700, 32'h0, c + 1, c + 3, 32'h0700F8FF, 1'b0, 1'b0);
    join

    repeat (5) @(negedge clk);
    check_vec("cmd_queue_empty", cmd_q.size(), 0);
    check_vec("ifu_queue_empty", ifu_q.size(), 0);
    check_vec("lsu_queue_empty", lsu_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
